// File: rtl/bitreg_write_scheduler.sv
// Write sequencer for the 8-bit bit-addressable output register.
// Arbitrates single-bit writes (A) against LSB-first word loads (B) onto the
// register's one bit-write port, and keeps a shadow of every bit written.
module bitreg_write_scheduler #(
   parameter int IDX_W = 3,
   localparam int N = 2 ** IDX_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [IDX_W-1:0] a_sel,
   input  logic             a_bit,
   input  logic             b_valid,
   output logic             b_ready,
   input  logic [N-1:0]     b_word,
   output logic             b_done,
   output logic             wr_en,
   output logic [IDX_W-1:0] wr_sel,
   output logic             wr_bit,
   output logic             busy,
   output logic [N-1:0]     shadow
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WR_A  = 2'd1,
      SER_B = 2'd2
   } state_t;

   state_t           state;
   logic             rr_last;   // 1: B was served last, 0: A was served last
   logic [N-1:0]     word_q;
   logic [IDX_W-1:0] cnt;
   logic [IDX_W-1:0] cnt_next;
   logic             grant_a;
   logic             grant_b;
   logic             open;

   assign cnt_next = cnt + IDX_W'(1);

   // Round-robin grant; readies only open in IDLE and never while in reset
   always_comb begin
      open    = (state == IDLE) && !reset;
      grant_a = a_valid && (!b_valid || rr_last);
      grant_b = b_valid && (!a_valid || !rr_last);
      a_ready = open && grant_a;
      b_ready = open && grant_b;
   end

   // Transaction sequencing, registered write-port outputs and shadow update
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         rr_last <= 1'b1;
         word_q  <= '0;
         cnt     <= '0;
         wr_en   <= 1'b0;
         wr_sel  <= '0;
         wr_bit  <= 1'b0;
         b_done  <= 1'b0;
         busy    <= 1'b0;
         shadow  <= '0;
      end else begin
         if (wr_en)
            shadow[wr_sel] <= wr_bit;

         case (state)
            IDLE: begin
               wr_en  <= 1'b0;
               b_done <= 1'b0;
               busy   <= 1'b0;
               if (a_ready) begin
                  state   <= WR_A;
                  rr_last <= 1'b0;
                  wr_en   <= 1'b1;
                  wr_sel  <= a_sel;
                  wr_bit  <= a_bit;
                  busy    <= 1'b1;
               end else if (b_ready) begin
                  state   <= SER_B;
                  rr_last <= 1'b1;
                  word_q  <= b_word;
                  cnt     <= '0;
                  wr_en   <= 1'b1;
                  wr_sel  <= '0;
                  wr_bit  <= b_word[0];
                  busy    <= 1'b1;
               end
            end

            WR_A: begin
               state <= IDLE;
               wr_en <= 1'b0;
               busy  <= 1'b0;
            end

            SER_B: begin
               // cnt tracks the index currently presented on wr_sel, so the
               // next bit and the b_done flag are looked up one index ahead
               if (cnt == IDX_W'(N - 1)) begin
                  state  <= IDLE;
                  cnt    <= '0;
                  wr_en  <= 1'b0;
                  b_done <= 1'b0;
                  busy   <= 1'b0;
               end else begin
                  cnt    <= cnt_next;
                  wr_sel <= cnt_next;
                  wr_bit <= word_q[cnt_next];
                  b_done <= (cnt_next == IDX_W'(N - 1));
               end
            end

            default: begin
               state <= IDLE;
               wr_en <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bitreg_write_scheduler.sv
// Directed self-checking bench for bitreg_write_scheduler.
module tb_bitreg_write_scheduler;

   logic       clk = 1'b0;
   logic       reset;
   logic       a_valid;
   logic       a_ready;
   logic [2:0] a_sel;
   logic       a_bit;
   logic       b_valid;
   logic       b_ready;
   logic [7:0] b_word;
   logic       b_done;
   logic       wr_en;
   logic [2:0] wr_sel;
   logic       wr_bit;
   logic       busy;
   logic [7:0] shadow;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   bitreg_write_scheduler #(.IDX_W(3)) dut (
      .clk     (clk),
      .reset   (reset),
      .a_valid (a_valid),
      .a_ready (a_ready),
      .a_sel   (a_sel),
      .a_bit   (a_bit),
      .b_valid (b_valid),
      .b_ready (b_ready),
      .b_word  (b_word),
      .b_done  (b_done),
      .wr_en   (wr_en),
      .wr_sel  (wr_sel),
      .wr_bit  (wr_bit),
      .busy    (busy),
      .shadow  (shadow)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // advance one rising edge and settle past it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      a_valid = 1'b0;
      a_sel   = '0;
      a_bit   = 1'b0;
      b_valid = 1'b0;
      b_word  = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      logic [7:0] pat;

      // ---------------- reset state, readies blocked during reset
      do_reset();
      reset   = 1'b1;
      a_valid = 1'b1;
      b_valid = 1'b1;
      #1;
      check("rst_a_ready", a_ready, 0);
      check("rst_b_ready", b_ready, 0);
      tick();
      a_valid = 1'b0;
      b_valid = 1'b0;
      check("rst_wr_en", wr_en, 0);
      check("rst_busy", busy, 0);
      check("rst_b_done", b_done, 0);
      check("rst_shadow", shadow, 8'h00);
      check("rst_wr_sel", wr_sel, 0);
      reset = 1'b0;

      // ---------------- single A write
      a_valid = 1'b1; a_sel = 3'd5; a_bit = 1'b1;
      #1;
      check("a1_ready", a_ready, 1);
      check("a1_b_ready", b_ready, 0);
      tick();
      a_valid = 1'b0;
      check("a1_wr_en", wr_en, 1);
      check("a1_wr_sel", wr_sel, 5);
      check("a1_wr_bit", wr_bit, 1);
      check("a1_busy", busy, 1);
      tick();
      check("a1_shadow", shadow, 8'h20);
      check("a1_wr_en_off", wr_en, 0);
      check("a1_busy_off", busy, 0);

      // ---------------- B serial load of A5
      do_reset();
      b_valid = 1'b1; b_word = 8'hA5;
      #1;
      check("b1_ready", b_ready, 1);
      tick();
      b_valid = 1'b0;
      b_word  = 8'h00;
      pat = 8'b1010_0101;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("b1_wr_en%0d", i), wr_en, 1);
         check($sformatf("b1_wr_sel%0d", i), wr_sel, i);
         check($sformatf("b1_wr_bit%0d", i), wr_bit, pat[i]);
         check($sformatf("b1_done%0d", i), b_done, (i == 7) ? 1 : 0);
         check($sformatf("b1_busy%0d", i), busy, 1);
         tick();
      end
      check("b1_busy_end", busy, 0);
      check("b1_wr_en_end", wr_en, 0);
      check("b1_done_end", b_done, 0);
      check("b1_shadow", shadow, 8'hA5);

      // ---------------- tie after reset: A, B, A, B
      do_reset();
      a_valid = 1'b1; a_sel = 3'd1; a_bit = 1'b1;
      b_valid = 1'b1; b_word = 8'h3C;
      #1;
      check("tie1_a", a_ready, 1);
      check("tie1_b", b_ready, 0);
      tick();
      check("tie1_wra_a", a_ready, 0);
      check("tie1_wra_b", b_ready, 0);
      tick();
      check("tie2_a", a_ready, 0);
      check("tie2_b", b_ready, 1);
      tick();
      check("tie2_ser_a", a_ready, 0);
      check("tie2_ser_b", b_ready, 0);
      repeat (8) tick();
      check("tie3_a", a_ready, 1);
      check("tie3_b", b_ready, 0);
      tick();
      tick();
      check("tie4_a", a_ready, 0);
      check("tie4_b", b_ready, 1);
      tick();
      a_valid = 1'b0;
      b_valid = 1'b0;
      repeat (8) tick();
      check("tie_shadow", shadow, 8'h3C);

      // ---------------- A arrives mid serial load
      do_reset();
      b_valid = 1'b1; b_word = 8'hFF;
      tick();
      b_valid = 1'b0;
      repeat (3) tick();
      check("ct_sel3", wr_sel, 3);
      a_valid = 1'b1; a_sel = 3'd2; a_bit = 1'b0;
      #1;
      check("ct_a_blocked", a_ready, 0);
      repeat (4) tick();
      check("ct_sel7", wr_sel, 7);
      check("ct_done", b_done, 1);
      check("ct_a_blocked7", a_ready, 0);
      tick();
      check("ct_a_idle", a_ready, 1);
      tick();
      a_valid = 1'b0;
      check("ct_wr_sel", wr_sel, 2);
      check("ct_wr_bit", wr_bit, 0);
      check("ct_wr_en", wr_en, 1);
      tick();
      check("ct_shadow", shadow, 8'hFB);

      // ---------------- reset mid serial load
      do_reset();
      b_valid = 1'b1; b_word = 8'hFF;
      tick();
      b_valid = 1'b0;
      repeat (5) tick();
      check("mr_sel5", wr_sel, 5);
      check("mr_shadow_pre", shadow, 8'h1F);
      reset = 1'b1;
      tick();
      check("mr_wr_en", wr_en, 0);
      check("mr_busy", busy, 0);
      check("mr_done", b_done, 0);
      check("mr_shadow", shadow, 8'h00);
      a_valid = 1'b1; a_sel = 3'd6; a_bit = 1'b1;
      #1;
      check("mr_a_in_reset", a_ready, 0);
      tick();
      reset = 1'b0;
      #1;
      check("mr_a_after", a_ready, 1);
      tick();
      a_valid = 1'b0;
      check("mr_a_wr_en", wr_en, 1);
      check("mr_a_wr_sel", wr_sel, 6);
      check("mr_b_done_quiet", b_done, 0);
      tick();
      check("mr_a_shadow", shadow, 8'h40);

      // ---------------- back-to-back A writes to bit 0
      do_reset();
      a_valid = 1'b1; a_sel = 3'd0; a_bit = 1'b1;
      #1;
      check("bb1_ready", a_ready, 1);
      tick();
      a_bit = 1'b0;
      check("bb1_wr_en", wr_en, 1);
      check("bb1_wr_bit", wr_bit, 1);
      check("bb1_a_held", a_ready, 0);
      tick();
      check("bb_gap_wr_en", wr_en, 0);
      check("bb_shadow1", shadow, 8'h01);
      check("bb2_ready", a_ready, 1);
      tick();
      a_valid = 1'b0;
      check("bb2_wr_en", wr_en, 1);
      check("bb2_wr_bit", wr_bit, 0);
      tick();
      check("bb_shadow0", shadow, 8'h00);
      check("bb_end_wr_en", wr_en, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
